// File: rtl/reg_file_scan_pkg.sv
// Shared definitions for the register file and its debug readback scanner.
// Holds datapath size defaults and the scan FSM state encoding.
// No logic; imported by reg_scan_ctrl and reg_file_scan.
package reg_file_scan_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int DEPTH_DEF = 32;

    typedef logic [1:0] scan_state_t;

    localparam scan_state_t IDLE    = 2'd0;
    localparam scan_state_t LOAD    = 2'd1;
    localparam scan_state_t PRESENT = 2'd2;
    localparam scan_state_t DONE    = 2'd3;

endpackage

// File: rtl/reg_scan_ctrl.sv
// Walks every register index and streams a snapshot of each on valid/ready.
// Latency: first element valid 2 edges after scan_start; 2 cycles per element.
// Backpressure: holds scan_idx/scan_data stable while scan_valid && !scan_ready.
module reg_scan_ctrl
    import reg_file_scan_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scan_start,
    input  logic             scan_ready,
    input  logic [WIDTH-1:0] rd_data,
    output logic             scan_valid,
    output logic [AW-1:0]    scan_idx,
    output logic [WIDTH-1:0] scan_data,
    output logic             scan_busy,
    output logic             scan_done
);

    scan_state_t state;
    scan_state_t state_nxt;
    logic        last_idx;

    assign last_idx = (scan_idx == AW'(DEPTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // scan_valid is always high in PRESENT, so scan_ready alone marks acceptance.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (scan_start) state_nxt = LOAD;
            LOAD:    state_nxt = PRESENT;
            PRESENT: if (scan_ready) state_nxt = last_idx ? DONE : LOAD;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        scan_done = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_idx   <= '0;
            scan_data  <= '0;
            scan_valid <= 1'b0;
            scan_busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (scan_start) begin
                        scan_idx  <= '0;
                        scan_busy <= 1'b1;
                    end
                end
                LOAD: begin
                    scan_data  <= rd_data;
                    scan_valid <= 1'b1;
                end
                PRESENT: begin
                    // Index stops at DEPTH-1 rather than wrapping.
                    if (scan_ready) begin
                        scan_valid <= 1'b0;
                        if (!last_idx) scan_idx <= scan_idx + AW'(1);
                    end
                end
                DONE: begin
                    scan_busy <= 1'b0;
                end
                default: begin
                    scan_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/reg_file_scan.sv
// CPU register file: one write port, two combinational read ports, plus debug scan.
// Latency: reads are combinational, writes land on the edge; scan as in reg_scan_ctrl.
// Backpressure: none on the CPU ports; the scan stream stalls on scan_ready.
module reg_file_scan
    import reg_file_scan_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RegWrite,
    input  logic [AW-1:0]    Wt_addr,
    input  logic [WIDTH-1:0] Wt_data,
    input  logic [AW-1:0]    R_addr_A,
    input  logic [AW-1:0]    R_addr_B,
    output logic [WIDTH-1:0] rdata_A,
    output logic [WIDTH-1:0] rdata_B,
    input  logic             scan_start,
    input  logic             scan_ready,
    output logic             scan_valid,
    output logic [AW-1:0]    scan_idx,
    output logic [WIDTH-1:0] scan_data,
    output logic             scan_busy,
    output logic             scan_done
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [WIDTH-1:0] scan_rd;

    // Register 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (RegWrite && (Wt_addr != '0)) begin
            regs[Wt_addr] <= Wt_data;
        end
    end

    assign rdata_A = regs[R_addr_A];
    assign rdata_B = regs[R_addr_B];
    assign scan_rd = regs[scan_idx];

    reg_scan_ctrl #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_scan (
        .clk       (clk),
        .rst       (rst),
        .scan_start(scan_start),
        .scan_ready(scan_ready),
        .rd_data   (scan_rd),
        .scan_valid(scan_valid),
        .scan_idx  (scan_idx),
        .scan_data (scan_data),
        .scan_busy (scan_busy),
        .scan_done (scan_done)
    );

endmodule

// File: tb/tb_reg_file_scan.sv
// Directed bench for reg_file_scan; scan elements are checked against a queue of expected values.
module tb_reg_file_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RegWrite = 1'b0;
    logic [4:0]  Wt_addr = '0;
    logic [31:0] Wt_data = '0;
    logic [4:0]  R_addr_A = '0;
    logic [4:0]  R_addr_B = '0;
    logic [31:0] rdata_A;
    logic [31:0] rdata_B;
    logic        scan_start = 1'b0;
    logic        scan_ready = 1'b0;
    logic        scan_valid;
    logic [4:0]  scan_idx;
    logic [31:0] scan_data;
    logic        scan_busy;
    logic        scan_done;

    reg_file_scan dut (
        .clk       (clk),
        .rst       (rst),
        .RegWrite  (RegWrite),
        .Wt_addr   (Wt_addr),
        .Wt_data   (Wt_data),
        .R_addr_A  (R_addr_A),
        .R_addr_B  (R_addr_B),
        .rdata_A   (rdata_A),
        .rdata_B   (rdata_B),
        .scan_start(scan_start),
        .scan_ready(scan_ready),
        .scan_valid(scan_valid),
        .scan_idx  (scan_idx),
        .scan_data (scan_data),
        .scan_busy (scan_busy),
        .scan_done (scan_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    int done_cnt = 0;
    int hs_cnt = 0;
    logic [63:0] exp_q[$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int idx, input logic [31:0] d);
        exp_q.push_back({27'd0, 5'(idx), d});
    endtask

    // Monitor: a handshake completes at the next rising edge when valid && ready.
    always @(negedge clk) begin
        if (!rst && scan_valid && scan_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scan_unexpected: got idx=%0d data=%h with nothing expected", scan_idx, scan_data);
            end else begin
                check("scan_elem", {27'd0, scan_idx, scan_data}, exp_q.pop_front());
            end
        end
        if (!rst && scan_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        RegWrite = 1'b1;
        Wt_addr  = a;
        Wt_data  = d;
        tick();
        RegWrite = 1'b0;
    endtask

    task automatic start_scan();
        scan_start = 1'b1;
        start_cyc  = cyc;
        tick();
        scan_start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int bound);
        int n = 0;
        while (done_cnt < target && n < bound) begin
            tick();
            n++;
        end
        check("done_seen", 64'(done_cnt), 64'(target));
        tick();
    endtask

    initial begin
        int n;
        int done0;
        logic [31:0] exp_d;

        // Reset state
        #12;
        check("rst_valid", 64'(scan_valid), 64'd0);
        check("rst_busy", 64'(scan_busy), 64'd0);
        check("rst_done", 64'(scan_done), 64'd0);
        check("rst_idx", 64'(scan_idx), 64'd0);
        check("rst_data", 64'(scan_data), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Write/read, no bypass, r0 discard
        R_addr_A = 5'd5;
        RegWrite = 1'b1; Wt_addr = 5'd5; Wt_data = 32'hDEADBEEF;
        #1;
        check("nobypass_first", 64'(rdata_A), 64'd0);
        tick();
        RegWrite = 1'b0;
        write_reg(5'd31, 32'h12345678);
        R_addr_A = 5'd5; R_addr_B = 5'd31;
        #1;
        check("rd_A_r5", 64'(rdata_A), 64'hDEADBEEF);
        check("rd_B_r31", 64'(rdata_B), 64'h12345678);
        write_reg(5'd0, 32'hFFFFFFFF);
        R_addr_A = 5'd0;
        #1;
        check("rd_r0_zero", 64'(rdata_A), 64'd0);
        R_addr_A = 5'd5;
        RegWrite = 1'b1; Wt_addr = 5'd5; Wt_data = 32'h00000055;
        #1;
        check("nobypass_old", 64'(rdata_A), 64'hDEADBEEF);
        tick();
        RegWrite = 1'b0;
        check("write_lands", 64'(rdata_A), 64'h00000055);

        // Full scan with ready held high
        for (int i = 1; i < 32; i++) write_reg(5'(i), 32'(i * 4));
        for (int i = 0; i < 32; i++) push_exp(i, 32'(i * 4));
        hs_cnt = 0;
        scan_ready = 1'b1;
        start_scan();
        check("lat_not_yet", 64'(scan_valid), 64'd0);
        check("busy_set", 64'(scan_busy), 64'd1);
        tick();
        check("lat_valid", 64'(scan_valid), 64'd1);
        wait_done(1, 200);
        check("full_latency", 64'(done_cyc - start_cyc), 64'd65);
        check("full_count", 64'(hs_cnt), 64'd32);
        check("full_q_empty", 64'(exp_q.size()), 64'd0);
        check("full_busy_clr", 64'(scan_busy), 64'd0);
        check("full_idx_hold", 64'(scan_idx), 64'd31);

        // Backpressure at idx 3
        for (int i = 0; i < 32; i++) push_exp(i, 32'(i * 4));
        hs_cnt = 0;
        start_scan();
        n = 0;
        while (!(scan_busy && scan_idx == 5'd3 && !scan_valid) && n < 100) begin
            tick();
            n++;
        end
        check("bp_reach_idx3", 64'(scan_idx), 64'd3);
        scan_ready = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", 64'(scan_valid), 64'd1);
            check("bp_idx", 64'(scan_idx), 64'd3);
            check("bp_data", 64'(scan_data), 64'd12);
            tick();
        end
        scan_ready = 1'b1;
        tick();
        check("bp_adv_idx", 64'(scan_idx), 64'd4);
        tick();
        check("bp_adv_valid", 64'(scan_valid), 64'd1);
        wait_done(2, 200);
        check("bp_count", 64'(hs_cnt), 64'd32);

        // Concurrent writes and ignored second start
        for (int i = 0; i < 32; i++) push_exp(i, (i == 20) ? 32'hAAAA0000 : 32'(i * 4));
        hs_cnt = 0;
        start_scan();
        n = 0;
        while (scan_idx != 5'd3 && n < 100) begin
            tick();
            n++;
        end
        check("cw_reach_idx3", 64'(scan_idx), 64'd3);
        RegWrite = 1'b1; Wt_addr = 5'd2; Wt_data = 32'hAAAA0000;
        tick();
        Wt_addr = 5'd20; scan_start = 1'b1;
        tick();
        RegWrite = 1'b0; scan_start = 1'b0;
        wait_done(3, 200);
        repeat (10) tick();
        check("cw_one_done", 64'(done_cnt), 64'd3);
        check("cw_count", 64'(hs_cnt), 64'd32);
        check("cw_idle_busy", 64'(scan_busy), 64'd0);
        R_addr_A = 5'd2;
        #1;
        check("cw_r2_written", 64'(rdata_A), 64'hAAAA0000);

        // Reset mid-scan at idx 10
        for (int i = 0; i < 10; i++) begin
            exp_d = (i == 2) ? 32'hAAAA0000 : 32'(i * 4);
            push_exp(i, exp_d);
        end
        hs_cnt = 0;
        done0 = done_cnt;
        start_scan();
        n = 0;
        while (!(scan_valid && scan_idx == 5'd10) && n < 100) begin
            tick();
            n++;
        end
        check("rs_reach_idx10", 64'(scan_idx), 64'd10);
        R_addr_A = 5'd5; R_addr_B = 5'd31;
        #2;
        rst = 1'b1;
        #1;
        check("rs_valid", 64'(scan_valid), 64'd0);
        check("rs_busy", 64'(scan_busy), 64'd0);
        check("rs_rdA", 64'(rdata_A), 64'd0);
        check("rs_rdB", 64'(rdata_B), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        repeat (4) tick();
        check("rs_no_done", 64'(done_cnt), 64'(done0));
        check("rs_count", 64'(hs_cnt), 64'd10);
        check("rs_q_empty", 64'(exp_q.size()), 64'd0);

        for (int i = 0; i < 32; i++) push_exp(i, 32'd0);
        hs_cnt = 0;
        start_scan();
        wait_done(done0 + 1, 200);
        check("rs2_count", 64'(hs_cnt), 64'd32);
        check("rs2_q_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_file_scan.md
Name: reg_file_scan

Overview:
- 32x32 CPU register file: one synchronous write port, two combinational read ports for the single-cycle datapath.
- Adds a sequential debug readback port that walks all registers and streams them out on a valid/ready handshake to the display/debug logic.
- The datapath registers are written by the CPU; this port is their reader.

Parameters:
- WIDTH, 32, data width of each register.
- DEPTH, 32, number of registers; must be a power of two.
- AW, 5, address width; equals log2(DEPTH).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state immediately.
- RegWrite  in  1  write enable.
- Wt_addr  in  AW  write address.
- Wt_data  in  WIDTH  write data.
- R_addr_A  in  AW  read address, port A.
- R_addr_B  in  AW  read address, port B.
- rdata_A  out  WIDTH  combinational read data, port A.
- rdata_B  out  WIDTH  combinational read data, port B.
- scan_start  in  1  one-cycle request to begin a full readback.
- scan_ready  in  1  consumer accepts the current element.
- scan_valid  out  1  scan_idx and scan_data are valid.
- scan_idx  out  AW  register index of the current element.
- scan_data  out  WIDTH  snapshot of register scan_idx.
- scan_busy  out  1  scan in progress.
- scan_done  out  1  one-cycle pulse after the last element is accepted.

Behaviour:
- Reset (async, while rst=1):
  - All registers are 0.
  - scan_valid=0, scan_busy=0, scan_done=0, scan_idx=0, scan_data=0.
  - FSM is in IDLE.
  - A reset mid-scan aborts the scan with no done pulse.
- Write:
  - On posedge, if RegWrite=1 and Wt_addr!=0, then regs[Wt_addr] <= Wt_data.
  - Writes to address 0 are discarded; register 0 always reads 0.
- Read:
  - rdata_A = regs[R_addr_A] and rdata_B = regs[R_addr_B], both purely combinational.
  - No write bypass: a read in the same cycle as a write to that address returns the old value until the edge.
- Scan FSM states: IDLE, LOAD, PRESENT, DONE.
  - IDLE:
    - If scan_start=1: go to LOAD, scan_idx <= 0, scan_busy <= 1.
    - Otherwise stay in IDLE.
  - LOAD:
    - scan_data <= regs[scan_idx], using the pre-edge value; a write to the same address in this cycle is not captured.
    - scan_valid <= 1; go to PRESENT.
  - PRESENT:
    - Hold scan_idx and scan_data stable while scan_valid=1 and scan_ready=0.
    - On scan_ready=1, clear scan_valid.
    - If scan_idx==DEPTH-1: go to DONE.
    - Otherwise scan_idx <= scan_idx+1 and go to LOAD.
  - DONE:
    - scan_done=1 for exactly one cycle; scan_busy <= 0; go to IDLE.
- Timing:
  - Throughput is one element per 2 cycles when scan_ready is held high.
  - Latency from scan_start to the first scan_valid is 2 edges.
  - A full scan with ready held high takes 2*DEPTH+1 cycles from start to done.
- Boundaries:
  - scan_start is ignored while scan_busy=1 or while in DONE.
  - scan_ready while scan_valid=0 is ignored.
  - The scan is not an atomic snapshot. Each element reflects the register value at its LOAD cycle: CPU writes to indices already captured are not seen; writes to indices not yet captured are seen.
  - Register 0 is always streamed as 0.
  - scan_idx does not wrap. The FSM leaves PRESENT at DEPTH-1 without incrementing, so scan_idx stays DEPTH-1 until the next start.
  - The write and read ports operate during a scan with no stalls and no priority interaction.

Decomposition:
- Shared package holds:
  - Scan state encoding constants: IDLE=2'd0, LOAD=2'd1, PRESENT=2'd2, DONE=2'd3.
  - WIDTH/DEPTH defaults shared with the datapath.
- One sub-module, reg_scan_ctrl: the FSM plus scan_idx/scan_data/handshake logic.
  - It receives the array read value through a third internal read port driven by scan_idx.
- The storage array and the write/read ports stay in the top module.

Test Plan:
- Reset during activity: assert rst asynchronously mid-cycle -> all regs read 0, scan_valid=0, and scan_busy=0 immediately, before the next clock edge.
- Write/read: write 32'hDEADBEEF to r5 and 32'h12345678 to r31; read A=5, B=31 -> rdata_A=32'hDEADBEEF, rdata_B=32'h12345678. Write 32'hFFFFFFFF to r0 -> rdata_A=0 when R_addr_A=0. A same-cycle read of r5 while writing r5 returns the old value.
- Full scan, ready held 1: preload r_i = i*4 -> 32 handshakes with scan_idx=0..31 and scan_data=0,4,...,124 (r0 yields 0). scan_done pulses once, 65 cycles after start.
- Backpressure: scan_ready=0 for 5 cycles at idx 3 -> scan_valid, scan_idx=3, and scan_data stay stable. Raising scan_ready advances to idx 4.
- Concurrent writes: during the scan, write 32'hAAAA0000 to r2 after it is captured and to r20 before its LOAD -> the stream shows the old r2 value and 32'hAAAA0000 for r20. A second scan_start mid-scan is ignored: exactly one done pulse, 32 elements.
- Reset mid-scan: assert rst at idx 10 -> scan_busy=0, no scan_done pulse, registers cleared. A new scan_start restarts from idx 0.
